// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide controller:
// operation encodings, FSM states and small decode helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } state_e;

  // Divide-class operations share the restoring-division datapath.
  function automatic logic op_is_div(input op_e o);
    return o[1];
  endfunction

  // MULHU and REMU take their result from the upper/remainder register.
  function automatic logic op_takes_acc(input op_e o);
    return o[0];
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Iterative unsigned multiply/divide controller: one bit per CALC cycle,
// using an external shared adder reached through the add_* ports.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_e           state, state_n;
  op_e              op_q;
  logic [WIDTH-1:0] b_q;
  // acc holds the product high half or the remainder; sh holds the
  // product low half / multiplier or the quotient / dividend.
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [WIDTH-1:0] res_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r;
  logic             take;

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (cnt == CW'(WIDTH - 1)) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One shift-add (multiply) or shift-subtract (divide) step per CALC cycle.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    acc_n   = acc;
    sh_n    = sh;
    take    = 1'b0;
    r       = {acc, sh[WIDTH-1]};
    if (state == CALC) begin
      if (op_is_div(op_q)) begin
        // r - b via r + ~b + 1; r's dropped MSB guarantees r >= b.
        add_x   = r[WIDTH-1:0];
        add_y   = ~b_q;
        add_cin = 1'b1;
        take    = add_cout | r[WIDTH];
        acc_n   = take ? add_sum : r[WIDTH-1:0];
        sh_n    = {sh[WIDTH-2:0], take};
      end else begin
        add_x = acc;
        add_y = sh[0] ? b_q : '0;
        acc_n = {add_cout, add_sum[WIDTH-1:1]};
        sh_n  = {add_sum[0], sh[WIDTH-1:1]};
      end
    end
    res_n = op_takes_acc(op_q) ? acc_n : sh_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      op_q   <= OP_MUL;
      b_q    <= '0;
      acc    <= '0;
      sh     <= '0;
      cnt    <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      done  <= (state_n == FIN);
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q <= op_e'(op);
            b_q  <= b;
            acc  <= '0;
            sh   <= a;
            cnt  <= '0;
          end
        end
        CALC: begin
          acc <= acc_n;
          sh  <= sh_n;
          cnt <= cnt + CW'(1);
          // Capture the final iteration's value as it is produced.
          if (state_n == FIN) result <= res_n;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, add_cin, add_cout;
  logic [W-1:0] result, add_x, add_y, add_sum;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared CLA32.
  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + (W+1)'(add_cin);

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = (2*W)'(x) * (2*W)'(y);
    case (o)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (y == '0) ? '1 : x / y;
      default: return (y == '0) ? x : x % y;
    endcase
  endfunction

  // Called #1 after a rising edge; start is high for one cycle (cycle 1).
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp);
    int cyc;
    start = 1'b1; op = o; a = x; b = y; cyc = 1;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom; cyc = 2;
    check({tag, "_busy"}, W'(busy), W'(1));
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_done"}, W'(done), W'(1));
    check({tag, "_lat"}, W'(cyc), W'(W + 2));
    check({tag, "_res"}, result, exp);
    @(posedge clk); #1;
    check({tag, "_pulse"}, W'({busy, done}), W'(0));
    check({tag, "_hold"}, result, exp);
  endtask

  initial begin
    int cyc;
    logic seen;
    logic [1:0] ro;
    logic [W-1:0] rx, ry;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_res", result, '0);
    check("rst_add", add_x | add_y | W'(add_cin), '0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("mul7x6", OP_MUL, 32'd7, 32'd6, 32'h0000002A);
    check("idle_add", add_x | add_y | W'(add_cin), '0);
    run_op("mulhu_max", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("mul_max", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    run_op("divu100_7", OP_DIVU, 32'd100, 32'd7, 32'd14);
    run_op("remu100_7", OP_REMU, 32'd100, 32'd7, 32'd2);
    run_op("divu_big", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF);
    run_op("remu_by0", OP_REMU, 32'd5, 32'd0, 32'd5);

    // A second start during CALC must not disturb the running MUL.
    start = 1'b1; op = OP_MUL; a = 32'd1234; b = 32'd5678; cyc = 1;
    @(posedge clk); #1; start = 1'b0; cyc = 2;
    while (cyc < 10) begin @(posedge clk); #1; cyc++; end
    start = 1'b1; op = OP_DIVU; a = 32'hDEAD; b = 32'd3;
    @(posedge clk); #1; start = 1'b0; cyc++;
    while (done !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check("ign_done", W'(done), W'(1));
    check("ign_lat", W'(cyc), W'(W + 2));
    check("ign_res", result, 32'd7006652);
    @(posedge clk); #1;

    // Asynchronous reset in cycle 10 aborts with no done pulse.
    start = 1'b1; op = OP_MUL; a = 32'd9; b = 32'd9; cyc = 1;
    @(posedge clk); #1; start = 1'b0; cyc = 2;
    while (cyc < 10) begin @(posedge clk); #1; cyc++; end
    #2 rst = 1'b1;
    #1;
    check("arst_busy", W'(busy), W'(0));
    check("arst_done", W'(done), W'(0));
    check("arst_res", result, '0);
    @(posedge clk); #1; rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= done; end
    check("arst_nodone", W'(seen), W'(0));
    run_op("post_rst", OP_MUL, 32'd9, 32'd9, 32'd81);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 3) == 0) ry = W'($urandom_range(1, 20));
      if ($urandom_range(0, 7) == 0) ry = '0;
      run_op($sformatf("rnd%0d_op%0d", i, ro), ro, rx, ry, model(ro, rx, ry));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; SHALL be accepted only in IDLE.
REQ-005 op  input  2  operation, sampled with start: 00 MUL (low half), 01 MULHU (high half), 10 DIVU, 11 REMU; all unsigned.
REQ-006 a  input  WIDTH  multiplicand or dividend, sampled with start.
REQ-007 b  input  WIDTH  multiplier or divisor, sampled with start.
REQ-008 busy  output  1  high from the cycle after accept until done.
REQ-009 done  output  1  one-cycle pulse when result becomes valid.
REQ-010 result  output  WIDTH  result, held from done until the next accept.
REQ-011 add_x, add_y  output  WIDTH  operands driven to the shared external carry-lookahead adder.
REQ-012 add_cin  output  1  carry-in to the shared adder.
REQ-013 add_sum  input  WIDTH  combinational sum returned by the shared adder.
REQ-014 add_cout  input  1  combinational carry-out returned by the shared adder.

Function
REQ-015 FSM states: IDLE, CALC, FIN; transitions: IDLE->CALC on start; CALC->FIN after exactly WIDTH iterations; FIN->IDLE unconditionally.
REQ-016 Latency: accept at edge N, done high during cycle N+WIDTH+1, i.e. WIDTH+2 cycles from start to done inclusive.
REQ-017 busy SHALL be high in CALC and FIN; done high only in FIN.
REQ-018 start while busy SHALL be ignored, with no effect on state, operands or result.
REQ-019 Multiply, per CALC cycle: add_x = hi, add_y = lo[0] ? b : 0, add_cin = 0; {hi, lo} <= {add_cout, add_sum, lo} >> 1; lo initialised to a, hi to 0.
REQ-020 Multiply result: MUL returns lo, MULHU returns hi, after WIDTH iterations.
REQ-021 Divide (restoring), per CALC cycle: r = {rem, q[WIDTH-1]}; add_x = r, add_y = ~b, add_cin = 1.
REQ-022 Divide update: if add_cout = 1 or the shifted-out rem MSB = 1, then rem <= add_sum and quotient bit 1; otherwise rem <= r and quotient bit 0; q shifts left.
REQ-023 Divide result: DIVU returns q, REMU returns rem.
REQ-024 Divide by zero SHALL yield DIVU = all ones and REMU = a, with unchanged latency.
REQ-025 Outside CALC, add_x, add_y and add_cin SHALL be driven to 0.
REQ-026 All arithmetic is modulo 2^WIDTH; no overflow flag.
REQ-027 result SHALL update only on the FIN entry edge.

Reset
REQ-028 On rst assertion, regardless of clock: state = IDLE, busy = 0, done = 0, result = 0, internal registers = 0.
REQ-029 Reset mid-operation SHALL abort the operation with no done pulse; the first start after deassertion SHALL behave as from power-up.

Structure
REQ-030 Shared package muldiv_pkg SHALL hold the op encodings (OP_MUL, OP_MULHU, OP_DIVU, OP_REMU) and the FSM state enum.
REQ-031 The iteration counter width SHALL be $clog2(WIDTH)+1, defined locally.
REQ-032 No internal sub-module: the adder SHALL be the team's existing CLA32, instantiated by the parent and shared through the add_* ports.

Verification
REQ-033 Bench SHALL attach a CLA32 to the add_* ports and cover the following scenarios.
REQ-034 MUL a=7, b=6 -> done exactly 34 cycles after the start edge, result = 0x0000002A.
REQ-035 MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result = 0xFFFFFFFE; MUL with the same operands -> result = 0x00000001.
REQ-036 DIVU 100/7 -> result = 14; REMU 100/7 -> result = 2; DIVU 0x80000000/0xFFFFFFFF -> result = 0.
REQ-037 DIVU 5/0 -> result = 0xFFFFFFFF; REMU 5/0 -> result = 5.
REQ-038 Start pulsed at cycle 10 of a MUL -> original result unchanged; rst at cycle 10 -> busy, done and result = 0 immediately, with no done pulse.
